instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Instruction-fetch initiator that drives the instruction memory's address/chip-select interface and consumes its combinational instruction word. It holds the PC and prefetches into a small FIFO of {pc, instr} entries. It presents fetched instructions to decode with a valid/ready handshake. Branch/jump redirects from execute flush the FIFO, and misaligned targets are trapped.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
FIFO_DEPTH, 2, prefetch entries; power of two, at least 2.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; synchronous, active-low
iaddr  out  32  byte address to instruction memory; equals current PC
cs_n  out  1  memory chip select, active-low; 0 = fetch this cycle
instrCode  in  32  instruction word for iaddr, valid in the same cycle (combinational memory)
redirect_valid  in  1  execute requests a PC change
redirect_pc  in  32  redirect target
if_valid  out  1  decode-side instruction valid
if_ready  in  1  decode accepts the head entry
if_instr  out  32  head instruction
if_pc  out  32  PC of the head instruction
misalign_exc  out  1  misaligned-redirect fault flag (level)
fault_pc  out  32  offending redirect target

Behaviour:
- Reset (rst=0 at an edge): state=BOOT, pc=RESET_PC, FIFO count=0, misalign_exc=0, fault_pc=0. Outputs while rst=0: iaddr=RESET_PC, cs_n=1, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0.
- States: BOOT, RUN, FAULT.
  - BOOT: lasts exactly 1 cycle after reset release; cs_n=1, no push. Gives the memory image time to load. Next state is RUN. A redirect during BOOT is handled as in RUN.
  - RUN: normal fetch.
  - FAULT: cs_n=1, no push, if_valid=0, misalign_exc=1. Leaves only on an aligned redirect, which goes to RUN with misalign_exc cleared.
- Fetch condition in RUN (fetch = !redirect_valid && (!full || pop)):
  - cs_n = !fetch; iaddr = pc in every state.
  - On a fetch edge: push {pc, instrCode}, then pc <= pc+4.
  - Wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Pop: pop = if_valid && if_ready.
  - if_valid = (count != 0) && !redirect_valid && state != FAULT.
  - if_instr/if_pc come from the FIFO head. When if_valid=0 they read NOP and 0.
- Simultaneous push and pop on a full FIFO: both happen and count is unchanged. Push on empty: the entry is visible next cycle, so fetch-to-decode latency is 1 cycle.
- Redirect has the highest priority. In the cycle redirect_valid=1: cs_n=1, no push, if_valid=0 (so no pop). At the edge:
  - FIFO is flushed (count=0, pointers reset).
  - If redirect_pc[1:0]==0: pc <= redirect_pc, state <= RUN.
  - Otherwise: pc is unchanged, fault_pc <= redirect_pc, state <= FAULT.
  - First instruction from the target reaches if_valid 2 cycles after the redirect cycle.
- Back-to-back redirects: the last one wins; each one flushes.
- Reset mid-operation: rst=0 overrides redirect and handshake; all state returns to reset values at that edge.
- FIFO count width is $clog2(FIFO_DEPTH)+1; count never exceeds FIFO_DEPTH.

Decomposition:
- Shared package fetch_pkg: NOP_INSTR=32'h0000_0013, PC_INCR=4, state encodings (BOOT, RUN, FAULT), and the entry width (64 bits = pc + instr).
- Sub-module fetch_fifo: synchronous FIFO with push, pop and flush, parameterised by DEPTH and WIDTH. Flush has priority over push and pop.
- instr_fetch holds the PC, the FSM and the handshake glue.

Test Plan:
1. Reset, then release with if_ready=1 and memory image word[i]=i+1: cs_n=1 for 1 cycle (BOOT). if_valid rises 2 cycles after release with if_pc=0, instr=1, then pc 4, 8, … streaming 1 per cycle.
2. Hold if_ready=0 from start: FIFO fills to 2 entries, then cs_n=1 and iaddr holds at 8. Raise if_ready: heads are pc 0 and 4 in order, with no loss or duplication.
3. Redirect to 32'h100 while the FIFO holds 2 entries: if_valid=0 in the redirect cycle. The next valid has if_pc=32'h100, 2 cycles later, and the old entries never appear.
4. Redirect to 32'h102: misalign_exc=1, fault_pc=32'h102, cs_n=1 and if_valid=0 held. A later redirect to 32'h200 clears the flag and fetch resumes at 32'h200.
5. Redirect to 32'hFFFF_FFFC: the streamed PCs are FFFF_FFFC, then 0000_0000, with no exception.
6. Assert rst=0 mid-stream with the FIFO full and a redirect pending: the next cycle shows if_valid=0, cs_n=1, misalign_exc=0, and iaddr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch block.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INCR   = 32'd4;
  localparam int unsigned ENTRY_W   = 64;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StFault
  } fetch_state_e;

  // One prefetched instruction and the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push, pop and flush; flush wins over both.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; reads are qualified by occupancy.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, BOOT/RUN/FAULT control, prefetch FIFO and decode handshake.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iaddr,
  output logic        cs_n,
  input  logic [31:0] instrCode,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_exc,
  output logic [31:0] fault_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  fault_pc_q, fault_pc_d;

  logic         fifo_full, fifo_empty;
  logic         head_valid, pop, fetch;
  fetch_entry_t push_entry, head_entry;
  logic [ENTRY_W-1:0] head_raw;

  assign push_entry = '{pc: pc_q, instr: instrCode};
  assign head_entry = fetch_entry_t'(head_raw);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (redirect_valid),
    .push_i  (fetch),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Handshake, fetch decision and next-state; redirect overrides everything but reset.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    fault_pc_d = fault_pc_q;
    head_valid = rst && !fifo_empty && !redirect_valid && (state_q != StFault);
    pop        = head_valid && if_ready;
    fetch      = rst && (state_q == StRun) && !redirect_valid && (!fifo_full || pop);
    if (redirect_valid) begin
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d       = redirect_pc;
        state_d    = StRun;
        misalign_d = 1'b0;
      end else begin
        fault_pc_d = redirect_pc;
        state_d    = StFault;
        misalign_d = 1'b1;
      end
    end else begin
      if (state_q == StBoot) begin
        state_d = StRun;
      end
      if (fetch) begin
        pc_d = pc_q + PC_INCR;
      end
    end
  end

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    iaddr        = rst ? pc_q : RESET_PC;
    cs_n         = !fetch;
    if_valid     = head_valid;
    if_instr     = head_valid ? head_entry.instr : NOP_INSTR;
    if_pc        = head_valid ? head_entry.pc : 32'h0;
    misalign_exc = misalign_q;
    fault_pc     = fault_pc_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      fault_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      fault_pc_q <= fault_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed plan steps followed by random traffic.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] iaddr;
  logic        cs_n;
  logic [31:0] instrCode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        misalign_exc;
  logic [31:0] fault_pc;

  instr_fetch #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .iaddr          (iaddr),
    .cs_n           (cs_n),
    .instrCode      (instrCode),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .misalign_exc   (misalign_exc),
    .fault_pc       (fault_pc)
  );

  // Memory image: word[i] = i + 1.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  assign instrCode = mem_word(iaddr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the PCs fetched but not yet consumed, plus the architectural PC.
  logic [31:0] m_q [$];
  logic [31:0] m_pc;
  logic [31:0] m_fault_pc;
  bit          m_boot;
  bit          m_fault;
  bit          m_rst_seen;

  // Last sampled DUT outputs, for directed checks.
  logic        s_valid, s_cs_n, s_misalign;
  logic [31:0] s_pc, s_instr, s_iaddr, s_fault_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    bit exp_valid, exp_pop, exp_fetch;
    @(negedge clk);
    s_valid = if_valid; s_cs_n = cs_n; s_misalign = misalign_exc;
    s_pc = if_pc; s_instr = if_instr; s_iaddr = iaddr; s_fault_pc = fault_pc;
    exp_valid = rst && (m_q.size() != 0) && !redirect_valid && !m_fault;
    exp_pop   = exp_valid && if_ready;
    exp_fetch = rst && !m_boot && !m_fault && !redirect_valid &&
                ((m_q.size() < DEPTH) || exp_pop);
    chk("if_valid", {31'b0, if_valid}, {31'b0, exp_valid});
    chk("cs_n", {31'b0, cs_n}, {31'b0, !exp_fetch});
    chk("iaddr", iaddr, rst ? m_pc : RESET_PC);
    chk("if_pc", if_pc, exp_valid ? m_q[0] : 32'h0);
    chk("if_instr", if_instr, exp_valid ? mem_word(m_q[0]) : NOP);
    if (m_rst_seen) begin
      chk("misalign_exc", {31'b0, misalign_exc}, {31'b0, m_fault});
      chk("fault_pc", fault_pc, m_fault_pc);
    end
    @(posedge clk);
    if (!rst) begin
      m_q.delete();
      m_pc       = RESET_PC;
      m_fault_pc = 32'h0;
      m_boot     = 1'b1;
      m_fault    = 1'b0;
      m_rst_seen = 1'b1;
    end else if (redirect_valid) begin
      m_q.delete();
      m_boot = 1'b0;
      if (redirect_pc[1:0] == 2'b00) begin
        m_pc    = redirect_pc;
        m_fault = 1'b0;
      end else begin
        m_fault    = 1'b1;
        m_fault_pc = redirect_pc;
      end
    end else begin
      m_boot = 1'b0;
      if (exp_pop) void'(m_q.pop_front());
      if (exp_fetch) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect_valid = 1'b0;
    step(); step();
    rst = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1; redirect_pc = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    m_q.delete(); m_pc = RESET_PC; m_fault_pc = 32'h0;
    m_boot = 1'b1; m_fault = 1'b0; m_rst_seen = 1'b0;

    // Boot and streaming.
    do_reset();
    step(); chk("boot_cs_n", {31'b0, s_cs_n}, 32'd1);
    step(); chk("first_fetch_iaddr", s_iaddr, 32'h0);
    step(); chk("first_valid", {31'b0, s_valid}, 32'd1);
    chk("first_pc", s_pc, 32'h0); chk("first_instr", s_instr, 32'd1);
    step(); chk("second_pc", s_pc, 32'h4);
    step(); chk("third_pc", s_pc, 32'h8);

    // Back-pressure fills the FIFO, then drains in order.
    if_ready = 1'b0;
    do_reset();
    repeat (4) step();
    chk("stall_cs_n", {31'b0, s_cs_n}, 32'd1);
    chk("stall_iaddr", s_iaddr, 32'h8);
    if_ready = 1'b1;
    step(); chk("drain_pc0", s_pc, 32'h0);
    step(); chk("drain_pc1", s_pc, 32'h4);

    // Redirect over a full FIFO.
    if_ready = 1'b0;
    do_reset();
    repeat (4) step();
    redirect(32'h100);
    chk("redir_valid", {31'b0, s_valid}, 32'd0);
    if_ready = 1'b1;
    step(); chk("redir_gap", {31'b0, s_valid}, 32'd0);
    step(); chk("redir_pc", s_pc, 32'h100);

    // Misaligned target traps; aligned one recovers.
    redirect(32'h102);
    step(); chk("fault_flag", {31'b0, s_misalign}, 32'd1);
    chk("fault_pc_val", s_fault_pc, 32'h102);
    repeat (2) step();
    redirect(32'h200);
    step(); chk("fault_clear", {31'b0, s_misalign}, 32'd0);
    step(); chk("resume_pc", s_pc, 32'h200);

    // PC wrap at the top of the address space.
    redirect(32'hFFFF_FFFC);
    step();
    step(); chk("wrap_pc0", s_pc, 32'hFFFF_FFFC);
    step(); chk("wrap_pc1", s_pc, 32'h0);
    chk("wrap_noexc", {31'b0, s_misalign}, 32'd0);

    // Reset beats a pending redirect with a full FIFO.
    if_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h302;
    step();
    rst = 1'b1; redirect_valid = 1'b0;
    step();
    chk("rst_valid", {31'b0, s_valid}, 32'd0);
    chk("rst_cs_n", {31'b0, s_cs_n}, 32'd1);
    chk("rst_misalign", {31'b0, s_misalign}, 32'd0);
    chk("rst_iaddr", s_iaddr, RESET_PC);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 5))
        0:       redirect_pc = 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4);
        1:       redirect_pc = ($urandom_range(0, 1023) * 4) + $urandom_range(1, 3);
        default: redirect_pc = $urandom_range(0, 1023) * 4;
      endcase
      rst = ($urandom_range(0, 199) != 0);
      step();
    end
    rst = 1'b1; redirect_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
